pe_sequencer: RTL
=================

// Module: pe_sequencer
// PURPOSE
//  Initiator/controller for one pe_unit. Accepts an operand-pair stream and issues it to the PE
//  slot-interleaved, driving the slot select, accumulator clear and rounder enable. After the
//  pipeline drains it reads back each rounded slot result as a valid/ready stream.
//  Sits between the operand buffers and the PE array.
// PARAMETERS
//  para_int_bits   7  integer bits of a PE operand/result word
//  para_frac_bits  9  fraction bits; DW = para_int_bits+para_frac_bits = 16
//  NUM_SLOTS       8  accumulator slots per PE (pe_add_number range 0..NUM_SLOTS-1)
//  LEN_W           8  width of the dot-product length field
//  PIPE_LAT        2  issue-to-accumulator-write latency of the PE (mul reg + acc reg)
// PORTS
//  clk                 in   1      clock, rising edge
//  rst_n               in   1      asynchronous reset, active low
//  cfg_start           in   1      1-cycle job start pulse
//  cfg_len             in   LEN_W  MACs per slot (1..2^LEN_W-1)
//  cfg_slots           in   4      slots in use (1..NUM_SLOTS)
//  cfg_conn            in   3      connection state, held to PE for the whole job
//  cfg_busy            out  1      job in progress (state != IDLE)
//  cfg_err             out  1      1-cycle pulse: start rejected
//  done                out  1      1-cycle pulse after last result handshake
//  op_valid/op_ready   in/out 1    operand stream handshake
//  op_a, op_b          in   DW     operand pair, order: elem k of slot 0..S-1, then elem k+1
//  pe_data_in_1/_2     out  DW     operands to PE
//  pe_mac_en           out  1      operand pair on pe_data_in_* is valid this cycle
//  pe_acc_clr          out  1      this MAC starts its slot from zero (travels with operand)
//  pe_add_number       out  4      slot select (MAC phase and readback phase)
//  pe_rounder_en       out  1      readback of slot pe_add_number
//  pe_connection_state out  3      = cfg_conn latched at start
//  pe_data_out         in   DW     rounded result of selected slot (combinational in PE)
//  res_valid/res_ready out/in 1    result stream handshake
//  res_data            out  DW     rounded result
//  res_slot            out  4      slot index of res_data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-job aborts at once. PE accumulators
//  are not cleared here; the next job's pe_acc_clr covers that.
//  FSM IDLE->MAC->DRAIN->ROUND->IDLE.
//  IDLE: op_ready=0. If cfg_start with cfg_len==0, cfg_slots==0 or cfg_slots>NUM_SLOTS,
//   pulse cfg_err next cycle and stay IDLE. Otherwise latch len/slots/conn and go to MAC.
//  MAC: op_ready=1. On op_valid&&op_ready, register the operands. The next cycle has
//   pe_mac_en=1, pe_data_in_*=op_a/op_b, pe_add_number=slot_cnt, pe_acc_clr=(elem_cnt==0).
//   No handshake means a bubble: pe_mac_en=0 and counters hold.
//   slot_cnt wraps slots-1->0 and increments elem_cnt. On the last pair (elem len-1, slot S-1)
//   drop op_ready and go to DRAIN.
//  DRAIN: wait PIPE_LAT+1 cycles (drain_cnt) so the last accumulator write lands, then ROUND.
//  ROUND: rd_slot 0..S-1. Drive pe_add_number=rd_slot and pe_rounder_en=1. When the output
//   register is free (!res_valid || res_ready), load pe_data_out/rd_slot into it and advance
//   rd_slot; otherwise hold rd_slot (stall).
//   After loading slot S-1, go to IDLE once that result handshakes; pulse done the same cycle.
//  res_valid is held with data stable until res_ready; back-to-back throughput is 1/cycle.
//  cfg_start while busy: ignored, no cfg_err. op_valid outside MAC: never accepted.
//  No arithmetic here; all values pass through bit-exact. Counters never exceed latched bounds.
// STRUCTURE
//  pe_pkg: DW/NUM_SLOTS localparams, typedef enum {IDLE,MAC,DRAIN,ROUND} seq_state_t,
//   typedef logic [DW-1:0] pe_word_t.
//  Sub-module pe_res_slice: 1-entry valid/ready output register (data+slot), reused by the
//   collector.
//  Everything else is in pe_sequencer: FSM, elem/slot/drain/rd counters, operand issue register.
// TESTING
//  len=3, slots=2, op_valid always 1 -> 6 MACs with pe_add_number 0,1,0,1,0,1,
//   pe_acc_clr on MACs 1-2 only; vs a PE model: res_slot 0,1 carry the correct rounded sums; done=1x.
//  op_valid toggling 1/0 -> pe_mac_en matches accepted pairs; sums identical to the no-gap run.
//  res_ready=0 for 5 cycles in ROUND -> res_data/res_slot stable, pe_add_number held, no result lost.
//  cfg_start with len=0, then slots=9 -> cfg_err pulses, cfg_busy stays 0, op_ready stays 0.
//  rst_n low mid-MAC, then a new job len=2, slots=1 -> outputs 0 during reset;
//   new results exclude stale partial sums.
//  cfg_start pulsed during DRAIN -> ignored; exactly slots results, then done.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared widths, slot count and FSM state type for the PE sequencer slice
package pe_pkg;
   localparam int para_int_bits  = 7;
   localparam int para_frac_bits = 9;
   localparam int DW             = para_int_bits + para_frac_bits;
   localparam int NUM_SLOTS      = 8;
   localparam int LEN_W          = 8;
   localparam int PIPE_LAT       = 2;
   typedef enum logic [1:0] {IDLE, MAC, DRAIN, ROUND} seq_state_t;
   typedef logic [DW-1:0] pe_word_t;
endpackage

// File: rtl/pe_res_slice.sv
// pe_res_slice: one-entry valid/ready output register holding a rounded result and its slot
module pe_res_slice
   import pe_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] in_data,
   input  logic [3:0]    in_slot,
   input  logic          ready,
   output logic          valid,
   output logic [DW-1:0] data,
   output logic [3:0]    slot,
   output logic          free
);
   assign free = !valid || ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= '0;
         slot  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= in_data;
         slot  <= in_slot;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end
endmodule

// File: rtl/pe_sequencer.sv
// pe_sequencer: issues a slot-interleaved operand stream to one PE, then reads back each
// rounded slot result as a valid/ready stream
module pe_sequencer
   import pe_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [3:0]       cfg_slots,
   input  logic [2:0]       cfg_conn,
   output logic             cfg_busy,
   output logic             cfg_err,
   output logic             done,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [DW-1:0]    op_a,
   input  logic [DW-1:0]    op_b,
   output logic [DW-1:0]    pe_data_in_1,
   output logic [DW-1:0]    pe_data_in_2,
   output logic             pe_mac_en,
   output logic             pe_acc_clr,
   output logic [3:0]       pe_add_number,
   output logic             pe_rounder_en,
   output logic [2:0]       pe_connection_state,
   input  logic [DW-1:0]    pe_data_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DW-1:0]    res_data,
   output logic [3:0]       res_slot
);
   localparam int DCW = $clog2(PIPE_LAT + 1);
   localparam logic [3:0] MAX_SLOTS = 4'(NUM_SLOTS);
   seq_state_t       state;
   logic [LEN_W-1:0] len, elem_cnt;
   logic [3:0]       slots, slot_cnt, rd_slot;
   logic [DCW-1:0]   drain_cnt;
   logic             rd_done, free, load, hs, last_slot, last, bad;
   assign hs        = op_valid && op_ready;
   assign last_slot = slot_cnt == slots - 4'd1;
   assign last      = last_slot && (elem_cnt == len - LEN_W'(1));
   assign bad       = (cfg_len == '0) || (cfg_slots == '0) || (cfg_slots > MAX_SLOTS);
   assign load      = (state == ROUND) && !rd_done && free;
   assign cfg_busy  = state != IDLE;
   pe_res_slice u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .in_data (pe_data_out),
      .in_slot (rd_slot),
      .ready   (res_ready),
      .valid   (res_valid),
      .data    (res_data),
      .slot    (res_slot),
      .free    (free)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state               <= IDLE;
         len                 <= '0;
         slots               <= '0;
         elem_cnt            <= '0;
         slot_cnt            <= '0;
         rd_slot             <= '0;
         drain_cnt           <= '0;
         rd_done             <= 1'b0;
         cfg_err             <= 1'b0;
         done                <= 1'b0;
         op_ready            <= 1'b0;
         pe_data_in_1        <= '0;
         pe_data_in_2        <= '0;
         pe_mac_en           <= 1'b0;
         pe_acc_clr          <= 1'b0;
         pe_add_number       <= '0;
         pe_rounder_en       <= 1'b0;
         pe_connection_state <= '0;
      end else begin
         cfg_err    <= 1'b0;
         done       <= 1'b0;
         pe_mac_en  <= 1'b0;
         pe_acc_clr <= 1'b0;
         case (state)
            IDLE: if (cfg_start) begin
               if (bad) cfg_err <= 1'b1;
               else begin
                  len                 <= cfg_len;
                  slots               <= cfg_slots;
                  pe_connection_state <= cfg_conn;
                  elem_cnt            <= '0;
                  slot_cnt            <= '0;
                  op_ready            <= 1'b1;
                  state               <= MAC;
               end
            end
            // acc_clr travels with the first element of each slot
            MAC: if (hs) begin
               pe_mac_en     <= 1'b1;
               pe_data_in_1  <= op_a;
               pe_data_in_2  <= op_b;
               pe_add_number <= slot_cnt;
               pe_acc_clr    <= elem_cnt == '0;
               if (last) begin
                  op_ready  <= 1'b0;
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end else if (last_slot) begin
                  slot_cnt <= '0;
                  elem_cnt <= elem_cnt + LEN_W'(1);
               end else slot_cnt <= slot_cnt + 4'd1;
            end
            DRAIN: if (drain_cnt == DCW'(PIPE_LAT)) begin
               rd_slot       <= '0;
               rd_done       <= 1'b0;
               pe_add_number <= '0;
               pe_rounder_en <= 1'b1;
               state         <= ROUND;
            end else drain_cnt <= drain_cnt + DCW'(1);
            // pe_add_number mirrors rd_slot so pe_data_out always matches the slot being loaded
            ROUND: if (load) begin
               if (rd_slot == slots - 4'd1) rd_done <= 1'b1;
               else begin
                  rd_slot       <= rd_slot + 4'd1;
                  pe_add_number <= rd_slot + 4'd1;
               end
            end else if (rd_done && res_valid && res_ready) begin
               done          <= 1'b1;
               pe_rounder_en <= 1'b0;
               pe_add_number <= '0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
